// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - LED blink sequencer: N ON/OFF blinks of programmable length
// All outputs are registered alongside the state; a phase ends when the prescaler wraps on the last base tick.
module led_blink_sequencer #(
    parameter int TICK_MAX = 24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] blink_cnt,
    input  logic [1:0] period_sel,
    output logic       led_out,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [1:0]    tick_cnt;
    logic [3:0]    remaining;
    logic [1:0]    phase;

    logic base_tick;
    logic phase_end;

    assign base_tick = (prescaler == PRE_MAX);
    assign phase_end = base_tick && (tick_cnt == phase);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            prescaler <= '0;
            tick_cnt  <= '0;
            remaining <= '0;
            phase     <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    led_out   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start && !abort && (blink_cnt != 4'd0)) begin
                        remaining <= blink_cnt;
                        phase     <= period_sel;
                        state     <= S_ON;
                        led_out   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_ON, S_OFF: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        prescaler <= '0;
                        tick_cnt  <= '0;
                        led_out   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (phase_end) begin
                        prescaler <= '0;
                        tick_cnt  <= '0;
                        if (state == S_ON) begin
                            state   <= S_OFF;
                            led_out <= 1'b0;
                        end else begin
                            remaining <= remaining - 4'd1;
                            // remaining is decremented here, so 1 means this was the last blink
                            if (remaining == 4'd1) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= S_ON;
                                led_out <= 1'b1;
                            end
                        end
                    end else begin
                        prescaler <= base_tick ? '0 : prescaler + 1'b1;
                        if (base_tick) begin
                            tick_cnt <= tick_cnt + 2'd1;
                        end
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    led_out   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    led_out   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb/tb_led_blink_sequencer.sv - self-checking bench for led_blink_sequencer
// Scenario table plus randomized traffic, checked against an arithmetic blink-schedule model.
module tb_led_blink_sequencer;

    localparam int TICK_MAX = 4;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       abort;
    logic [3:0] blink_cnt;
    logic [1:0] period_sel;
    logic       led_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    led_blink_sequencer #(.TICK_MAX(TICK_MAX)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .abort      (abort),
        .blink_cnt  (blink_cnt),
        .period_sel (period_sel),
        .led_out    (led_out),
        .busy       (busy),
        .done       (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Model: a running sequence is just (cycles elapsed, blinks, phase length).
    bit m_active = 0;
    int m_t      = 0;
    int m_n      = 0;
    int m_len    = 0;

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            if (start && !abort && blink_cnt != 4'd0) begin
                m_active = 1;
                m_t      = 0;
                m_n      = int'(blink_cnt);
                m_len    = (int'(period_sel) + 1) * (TICK_MAX + 1);
            end
        end else if (abort) begin
            m_active = 0;
        end else begin
            m_t++;
            if (m_t >= 2 * m_n * m_len + 1) m_active = 0;
        end
    endtask

    task automatic model_out(output bit e_led, output bit e_busy, output bit e_done);
        int c;
        e_led = 0; e_busy = 0; e_done = 0;
        if (m_active) begin
            c = m_t + 1;
            e_busy = 1;
            if (c <= 2 * m_n * m_len) e_led = ((c - 1) % (2 * m_len)) < m_len;
            else e_done = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the following falling edge.
    task automatic cycle();
        bit e_led, e_busy, e_done;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        model_out(e_led, e_busy, e_done);
        check("led_out", int'(led_out), int'(e_led));
        check("busy", int'(busy), int'(e_busy));
        check("done", int'(done), int'(e_done));
    endtask

    typedef struct {
        logic [3:0] bc;
        logic [1:0] ps;
        int         abort_at;
        int         restart_at;
        int         exp_done;
        int         exp_on;
    } scen_t;

    scen_t tbl[7];

    task automatic run_scen(input scen_t s);
        int done_at = 0;
        int on_cnt  = 0;
        int done_n  = 0;
        int n_cyc;
        n_cyc = ((s.exp_done > 0) ? s.exp_done : 30) + 3;
        start = 1'b1; abort = 1'b0; blink_cnt = s.bc; period_sel = s.ps;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            if (led_out) on_cnt++;
            if (done) begin done_n++; done_at = c; end
            abort = (c == s.abort_at);
            if (c == s.restart_at) begin start = 1'b1; blink_cnt = 4'd9; end
            cycle();
            start = 1'b0; abort = 1'b0;
        end
        check("done_cycle", done_at, s.exp_done);
        check("on_cycles", on_cnt, s.exp_on);
        check("done_pulses", done_n, (s.exp_done != 0) ? 1 : 0);
        check("idle_after", int'(busy), 0);
    endtask

    initial begin
        sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0; blink_cnt = 4'd0; period_sel = 2'd0;
        tbl[0] = '{bc: 4'd2,  ps: 2'd0, abort_at: 0, restart_at: 0, exp_done: 21,  exp_on: 10};
        tbl[1] = '{bc: 4'd1,  ps: 2'd3, abort_at: 0, restart_at: 0, exp_done: 41,  exp_on: 20};
        tbl[2] = '{bc: 4'd0,  ps: 2'd1, abort_at: 0, restart_at: 0, exp_done: 0,   exp_on: 0};
        tbl[3] = '{bc: 4'd2,  ps: 2'd0, abort_at: 7, restart_at: 0, exp_done: 0,   exp_on: 5};
        tbl[4] = '{bc: 4'd2,  ps: 2'd0, abort_at: 0, restart_at: 0, exp_done: 21,  exp_on: 10};
        tbl[5] = '{bc: 4'd2,  ps: 2'd0, abort_at: 0, restart_at: 3, exp_done: 21,  exp_on: 10};
        tbl[6] = '{bc: 4'd15, ps: 2'd0, abort_at: 0, restart_at: 0, exp_done: 151, exp_on: 75};

        @(posedge sys_clk);
        #1;
        check("rst_led", int'(led_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 7; i++) run_scen(tbl[i]);

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; blink_cnt = 4'd3; period_sel = 2'd0;
        cycle();
        start = 1'b0; abort = 1'b0;
        check("abort_prio_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) cycle();

        // asynchronous reset in the middle of an ON phase
        start = 1'b1; blink_cnt = 4'd3; period_sel = 2'd1;
        cycle();
        start = 1'b0;
        cycle(); cycle();
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(led_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        #9 sys_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) cycle();

        // start taken on the very first edge after reset release
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #10 sys_rst_n = 1'b1;
        model_reset();
        start = 1'b1; blink_cnt = 4'd1; period_sel = 2'd0;
        cycle();
        start = 1'b0;
        check("first_edge_start", int'(led_out), 1);
        for (int i = 0; i < 12; i++) cycle();

        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            blink_cnt  = 4'($urandom_range(0, 15));
            period_sel = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
